// File: rtl/exec_pwr_seq.sv
// Power-gating sequencer for the EXEC domain: isolate -> switch off -> switch on
// -> power-on reset -> de-isolate, gated by the power-switch acknowledge.
module exec_pwr_seq #(
  parameter int unsigned IDLE_LIMIT  = 10,
  parameter int unsigned ISO_SETUP   = 2,
  parameter int unsigned PWR_UP_WAIT = 4,
  parameter int unsigned RST_CYCLES  = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pg_enable,
  input  logic        ififo_rdy,
  input  logic        exec_idle,
  input  logic        pwr_ack,
  output logic        iso_enable,
  output logic        pwr_down,
  output logic        pwron_reset,
  output logic        exec_ready,
  output logic [2:0]  pwr_state,
  output logic [15:0] off_count
);

  typedef enum logic [2:0] {
    ST_ON      = 3'd0,
    ST_ISO     = 3'd1,
    ST_OFF_REQ = 3'd2,
    ST_OFF     = 3'd3,
    ST_ON_REQ  = 3'd4,
    ST_RST     = 3'd5,
    ST_DEISO   = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_LIMIT - 1);
  localparam logic [CNT_W-1:0] ISO_LAST  = CNT_W'(ISO_SETUP - 1);
  localparam logic [CNT_W-1:0] UP_LAST   = CNT_W'(PWR_UP_WAIT - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);

  state_t            state_r;
  state_t            next_state_s;
  logic [CNT_W-1:0]  timer_r;
  logic [CNT_W-1:0]  timer_nxt_s;
  logic [CNT_W-1:0]  timer_inc_s;
  logic [15:0]       off_count_r;
  logic              idle_ok_s;
  logic              iso_r;
  logic              pd_r;
  logic              por_r;
  logic              rdy_r;
  logic [3:0]        outs_nxt_s;

  // Output pattern {iso_enable, pwr_down, pwron_reset, exec_ready} for a state
  function automatic logic [3:0] decode_outs(input state_t st);
    logic [3:0] o;
    case (st)
      ST_ON:      o = 4'b0001;
      ST_ISO:     o = 4'b1000;
      ST_OFF_REQ: o = 4'b1100;
      ST_OFF:     o = 4'b1100;
      ST_ON_REQ:  o = 4'b1000;
      ST_RST:     o = 4'b1010;
      ST_DEISO:   o = 4'b1000;
      default:    o = 4'b0001;
    endcase
    return o;
  endfunction

  assign idle_ok_s = pg_enable & exec_idle & ~ififo_rdy;

  // Next-state decode
  always_comb begin
    next_state_s = ST_ON;
    case (state_r)
      ST_ON: begin
        if (idle_ok_s && (timer_r == IDLE_LAST)) next_state_s = ST_ISO;
        else                                      next_state_s = ST_ON;
      end
      ST_ISO: begin
        if (ififo_rdy || !pg_enable)   next_state_s = ST_DEISO;
        else if (timer_r == ISO_LAST)  next_state_s = ST_OFF_REQ;
        else                           next_state_s = ST_ISO;
      end
      ST_OFF_REQ: begin
        // wake requests are ignored until the switch confirms it is off
        if (!pwr_ack) next_state_s = ST_OFF;
        else          next_state_s = ST_OFF_REQ;
      end
      ST_OFF: begin
        if (ififo_rdy || !pg_enable) next_state_s = ST_ON_REQ;
        else                         next_state_s = ST_OFF;
      end
      ST_ON_REQ: begin
        if ((timer_r >= UP_LAST) && pwr_ack) next_state_s = ST_RST;
        else                                 next_state_s = ST_ON_REQ;
      end
      ST_RST: begin
        if (timer_r == RST_LAST) next_state_s = ST_DEISO;
        else                     next_state_s = ST_RST;
      end
      ST_DEISO: next_state_s = ST_ON;
      default:  next_state_s = ST_ON;
    endcase
  end

  // Shared timer: restarts on every state change and on broken idle streaks in ON
  always_comb begin
    timer_inc_s = (&timer_r) ? timer_r : (timer_r + CNT_W'(1));
    if (next_state_s != state_r) begin
      timer_nxt_s = {CNT_W{1'b0}};
    end else if ((state_r == ST_ON) && !idle_ok_s) begin
      timer_nxt_s = {CNT_W{1'b0}};
    end else begin
      timer_nxt_s = timer_inc_s;
    end
  end

  assign outs_nxt_s = decode_outs(next_state_s);

  // State, timer, power-down counter and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_ON;
      timer_r     <= {CNT_W{1'b0}};
      off_count_r <= 16'd0;
      iso_r       <= 1'b0;
      pd_r        <= 1'b0;
      por_r       <= 1'b0;
      rdy_r       <= 1'b1;
    end else begin
      state_r <= next_state_s;
      timer_r <= timer_nxt_s;
      if ((next_state_s == ST_OFF) && (state_r != ST_OFF) && (off_count_r != 16'hFFFF)) begin
        off_count_r <= off_count_r + 16'd1;
      end else begin
        off_count_r <= off_count_r;
      end
      {iso_r, pd_r, por_r, rdy_r} <= outs_nxt_s;
    end
  end

  assign iso_enable  = iso_r;
  assign pwr_down    = pd_r;
  assign pwron_reset = por_r;
  assign exec_ready  = rdy_r;
  assign pwr_state   = state_r;
  assign off_count   = off_count_r;

endmodule

// File: tb/tb_exec_pwr_seq.sv
// Directed bench for exec_pwr_seq: power-down/wake sequences, aborts, idle-streak
// clearing, pg_enable handling, deferred wake and asynchronous reset.
module tb_exec_pwr_seq;

  localparam logic [2:0] S_ON     = 3'd0;
  localparam logic [2:0] S_ISO    = 3'd1;
  localparam logic [2:0] S_OFFREQ = 3'd2;
  localparam logic [2:0] S_OFF    = 3'd3;
  localparam logic [2:0] S_ONREQ  = 3'd4;
  localparam logic [2:0] S_RST    = 3'd5;
  localparam logic [2:0] S_DEISO  = 3'd6;

  // {iso_enable, pwr_down, pwron_reset, exec_ready}
  localparam logic [3:0] O_ON  = 4'b0001;
  localparam logic [3:0] O_ISO = 4'b1000;
  localparam logic [3:0] O_PD  = 4'b1100;
  localparam logic [3:0] O_RST = 4'b1010;

  logic        clk = 1'b0;
  logic        reset;
  logic        pg_enable;
  logic        ififo_rdy;
  logic        exec_idle;
  logic        pwr_ack;
  logic        iso_enable;
  logic        pwr_down;
  logic        pwron_reset;
  logic        exec_ready;
  logic [2:0]  pwr_state;
  logic [15:0] off_count;

  int n_cmp = 0;
  int n_mis = 0;

  exec_pwr_seq dut (
    .clk         (clk),
    .reset       (reset),
    .pg_enable   (pg_enable),
    .ififo_rdy   (ififo_rdy),
    .exec_idle   (exec_idle),
    .pwr_ack     (pwr_ack),
    .iso_enable  (iso_enable),
    .pwr_down    (pwr_down),
    .pwron_reset (pwron_reset),
    .exec_ready  (exec_ready),
    .pwr_state   (pwr_state),
    .off_count   (off_count)
  );

  always #5 clk = ~clk;

  // Power-switch model: pwr_ack = !pwr_down through two flops
  logic ack_d1 = 1'b1;
  logic ack_d2 = 1'b1;
  always @(posedge clk) begin
    ack_d1 <= ~pwr_down;
    ack_d2 <= ack_d1;
  end
  assign pwr_ack = ack_d2;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_st(input string tag, input logic [2:0] st, input logic [3:0] outs);
    check({tag, "_state"}, {13'd0, pwr_state}, {13'd0, st});
    check({tag, "_outs"}, {12'd0, iso_enable, pwr_down, pwron_reset, exec_ready}, {12'd0, outs});
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("inv_pd_iso", {15'd0, pwr_down & ~iso_enable}, 16'd0);
      check("inv_por_pd", {15'd0, pwron_reset & pwr_down}, 16'd0);
      check("inv_rdy", {15'd0, exec_ready & (iso_enable | pwr_down | pwron_reset)}, 16'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    pg_enable = 1'b1;
    exec_idle = 1'b1;
    ififo_rdy = 1'b0;
    @(posedge clk);
    #1;
    exp_st("reset", S_ON, O_ON);
    check("reset_cnt", off_count, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // idle streak -> power-down
    tick(9);  exp_st("on_9idle", S_ON, O_ON);
    tick(1);  exp_st("iso_entry", S_ISO, O_ISO);
    tick(1);  exp_st("iso_hold", S_ISO, O_ISO);
    tick(1);  exp_st("offreq", S_OFFREQ, O_PD);
    tick(2);  exp_st("offreq_wait", S_OFFREQ, O_PD);
    tick(1);  exp_st("off", S_OFF, O_PD);
    check("off_cnt1", off_count, 16'd1);
    tick(3);  exp_st("off_hold", S_OFF, O_PD);

    // wake from OFF via ififo_rdy pulse
    ififo_rdy = 1'b1;
    tick(1);  exp_st("onreq", S_ONREQ, O_ISO);
    ififo_rdy = 1'b0;
    tick(3);  exp_st("onreq_hold", S_ONREQ, O_ISO);
    tick(1);  exp_st("rst", S_RST, O_RST);
    tick(2);  exp_st("rst_hold", S_RST, O_RST);
    tick(1);  exp_st("deiso", S_DEISO, O_ISO);
    tick(1);  exp_st("on_again", S_ON, O_ON);

    // wake in first ISO cycle aborts
    tick(9);  exp_st("on_9idle_b", S_ON, O_ON);
    tick(1);  exp_st("iso_b", S_ISO, O_ISO);
    ififo_rdy = 1'b1;
    tick(1);  exp_st("abort_deiso", S_DEISO, O_ISO);
    ififo_rdy = 1'b0;
    tick(1);  exp_st("abort_on", S_ON, O_ON);
    check("abort_cnt", off_count, 16'd1);

    // broken idle streak restarts the count
    tick(9);  exp_st("streak9", S_ON, O_ON);
    exec_idle = 1'b0;
    tick(1);  exp_st("busy", S_ON, O_ON);
    exec_idle = 1'b1;
    tick(9);  exp_st("idle_cleared", S_ON, O_ON);
    tick(1);  exp_st("iso_c", S_ISO, O_ISO);

    // pg_enable drop in ISO aborts, then stays on
    pg_enable = 1'b0;
    tick(1);  exp_st("pg_deiso", S_DEISO, O_ISO);
    tick(1);  exp_st("pg_on", S_ON, O_ON);
    tick(100); exp_st("pg_off_100", S_ON, O_ON);

    // second power-down, woken by pg_enable drop in OFF
    pg_enable = 1'b1;
    tick(10); exp_st("iso_d", S_ISO, O_ISO);
    tick(2);  exp_st("offreq_d", S_OFFREQ, O_PD);
    tick(3);  exp_st("off_d", S_OFF, O_PD);
    check("off_cnt2", off_count, 16'd2);
    pg_enable = 1'b0;
    tick(1);  exp_st("pg_onreq", S_ONREQ, O_ISO);
    tick(4);  exp_st("pg_rst", S_RST, O_RST);
    tick(3);  exp_st("pg_deiso2", S_DEISO, O_ISO);
    tick(1);  exp_st("pg_wake_on", S_ON, O_ON);

    // wake in OFF_REQ is deferred until OFF
    pg_enable = 1'b1;
    tick(10); exp_st("iso_e", S_ISO, O_ISO);
    tick(2);  exp_st("offreq_e", S_OFFREQ, O_PD);
    ififo_rdy = 1'b1;
    tick(2);  exp_st("defer", S_OFFREQ, O_PD);
    tick(1);  exp_st("defer_off", S_OFF, O_PD);
    check("off_cnt3", off_count, 16'd3);
    tick(1);  exp_st("defer_onreq", S_ONREQ, O_ISO);
    ififo_rdy = 1'b0;
    tick(4);  exp_st("defer_rst", S_RST, O_RST);
    tick(3);  exp_st("defer_deiso", S_DEISO, O_ISO);
    tick(1);  exp_st("defer_on", S_ON, O_ON);

    // asynchronous reset while OFF
    tick(10); exp_st("iso_f", S_ISO, O_ISO);
    tick(2);  exp_st("offreq_f", S_OFFREQ, O_PD);
    tick(3);  exp_st("off_f", S_OFF, O_PD);
    check("off_cnt4", off_count, 16'd4);
    #2;
    reset = 1'b1;
    #1;
    exp_st("async_rst", S_ON, O_ON);
    check("async_rst_cnt", off_count, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(3);  exp_st("post_rst", S_ON, O_ON);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
